// File: rtl/mem_stage_pkg.sv
// Shared encodings and helpers for the data-memory access stage.
// Holds funct3 load/store encodings, writeback select codes and the MEM/WB register layout.
package mem_stage_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [2:0] {
    SB = 3'b000,
    SH = 3'b001,
    SW = 3'b010
  } store_funct3_e;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] alu_res;
    logic [XLEN-1:0] mem_data;
    logic [1:0]      wbsel;
    logic            brtaken;
    logic [4:0]      rd;
    logic            regwren;
    logic            misaligned;
  } mem_wb_t;

  // Pick the addressed byte/half out of a RAM word and extend it to XLEN.
  function automatic logic [XLEN-1:0] load_extend(logic [XLEN-1:0] word, logic [1:0] lane,
                                                  logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*lane +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      LB:      load_extend = {{24{b[7]}}, b};
      LH:      load_extend = {{16{h[15]}}, h};
      LW:      load_extend = word;
      LBU:     load_extend = {24'd0, b};
      LHU:     load_extend = {16'd0, h};
      default: load_extend = '0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised data RAM: byte-enable synchronous write, combinational read.
// Contents are deliberately not reset.
module dmem_array #(
  parameter int unsigned DepthWords = 1024,
  parameter int unsigned AddrW      = $clog2(DepthWords)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [3:0]       be_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DepthWords];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// Pipeline MEM stage: address decode, store lane steering, load extension and the
// MEM/WB register feeding writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DWIDTH      = 32,
  parameter int unsigned AWIDTH      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] alu_res_i,
  input  logic [DWIDTH-1:0] rs2_data_i,
  input  logic              memren_i,
  input  logic              memwren_i,
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        wbsel_i,
  input  logic              brtaken_i,
  input  logic [4:0]        rd_i,
  input  logic              regwren_i,
  output logic              valid_o,
  output logic [AWIDTH-1:0] pc_o,
  output logic [DWIDTH-1:0] alu_res_o,
  output logic [1:0]        wbsel_o,
  output logic              brtaken_o,
  output logic [4:0]        rd_o,
  output logic              regwren_o,
  output logic [DWIDTH-1:0] memory_data_o,
  output logic              misaligned_o
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);

  logic [AWIDTH-1:0] offset;
  logic              in_range;
  logic [IdxW-1:0]   word_idx;
  logic [1:0]        lane;
  logic              misaligned;
  logic              access;
  logic [3:0]        st_be;
  logic [31:0]       st_wdata;
  logic              st_en;
  logic [31:0]       rdata;
  logic [31:0]       load_data;

  mem_wb_t wb_d, wb_q;

  // Offset wraps for addresses below BASE_ADDR, so one unsigned compare covers both sides.
  assign offset     = AWIDTH'(alu_res_i) - AWIDTH'(BASE_ADDR);
  assign in_range   = offset < AWIDTH'(DEPTH_WORDS * 4);
  assign word_idx   = offset[IdxW+1:2];
  assign lane       = offset[1:0];
  assign access     = memren_i | memwren_i;
  assign misaligned = ((funct3_i[1:0] == 2'b01) && lane[0]) ||
                      ((funct3_i[1:0] == 2'b10) && (lane != 2'b00));

  always_comb begin
    st_be    = 4'b0000;
    st_wdata = '0;
    case (funct3_i)
      SB: begin
        st_be    = 4'b0001 << lane;
        st_wdata = {4{rs2_data_i[7:0]}};
      end
      SH: begin
        st_be    = lane[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{rs2_data_i[15:0]}};
      end
      SW: begin
        st_be    = 4'b1111;
        st_wdata = rs2_data_i[31:0];
      end
      default: ;
    endcase
  end

  // A store landing on the same edge as reset is suppressed.
  assign st_en = valid_i & memwren_i & ~stall_i & ~flush_i & ~reset &
                 in_range & ~misaligned & (st_be != 4'b0000);

  dmem_array #(
    .DepthWords(DEPTH_WORDS),
    .AddrW     (IdxW)
  ) u_dmem (
    .clk_i  (clk),
    .we_i   (st_en),
    .be_i   (st_be),
    .addr_i (word_idx),
    .wdata_i(st_wdata),
    .rdata_o(rdata)
  );

  assign load_data = (memren_i && in_range && !misaligned) ?
                     load_extend(rdata, lane, funct3_i) : '0;

  always_comb begin
    wb_d = wb_q;
    if (flush_i) begin
      wb_d = '0;
    end else if (!stall_i) begin
      wb_d.valid      = valid_i;
      wb_d.pc         = pc_i;
      wb_d.alu_res    = alu_res_i;
      wb_d.mem_data   = load_data;
      wb_d.wbsel      = wbsel_i;
      wb_d.brtaken    = brtaken_i;
      wb_d.rd         = rd_i;
      wb_d.regwren    = valid_i & regwren_i;
      wb_d.misaligned = valid_i & access & in_range & misaligned;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  assign valid_o       = wb_q.valid;
  assign pc_o          = wb_q.pc;
  assign alu_res_o     = wb_q.alu_res;
  assign memory_data_o = wb_q.mem_data;
  assign wbsel_o       = wb_q.wbsel;
  assign brtaken_o     = wb_q.brtaken;
  assign rd_o          = wb_q.rd;
  assign regwren_o     = wb_q.regwren;
  assign misaligned_o  = wb_q.misaligned;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus random traffic against a
// byte-addressed reference memory model.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [31:0] Base     = 32'h0100_0000;
  localparam int unsigned RamBytes = 4096;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i, stall_i, flush_i;
  logic [31:0] pc_i, alu_res_i, rs2_data_i;
  logic        memren_i, memwren_i;
  logic [2:0]  funct3_i;
  logic [1:0]  wbsel_i;
  logic        brtaken_i;
  logic [4:0]  rd_i;
  logic        regwren_i;
  logic        valid_o;
  logic [31:0] pc_o, alu_res_o, memory_data_o;
  logic [1:0]  wbsel_o;
  logic        brtaken_o;
  logic [4:0]  rd_o;
  logic        regwren_o, misaligned_o;

  int n_vec  = 0;
  int n_fail = 0;

  // Reference state: RAM as bytes, plus the expected MEM/WB outputs.
  logic [7:0]  model_b [RamBytes];
  logic        e_valid, e_br, e_rwe, e_mis;
  logic [31:0] e_pc, e_alu, e_data;
  logic [1:0]  e_wbsel;
  logic [4:0]  e_rd;

  mem_stage dut (
    .clk          (clk),
    .reset        (reset),
    .valid_i      (valid_i),
    .stall_i      (stall_i),
    .flush_i      (flush_i),
    .pc_i         (pc_i),
    .alu_res_i    (alu_res_i),
    .rs2_data_i   (rs2_data_i),
    .memren_i     (memren_i),
    .memwren_i    (memwren_i),
    .funct3_i     (funct3_i),
    .wbsel_i      (wbsel_i),
    .brtaken_i    (brtaken_i),
    .rd_i         (rd_i),
    .regwren_i    (regwren_i),
    .valid_o      (valid_o),
    .pc_o         (pc_o),
    .alu_res_o    (alu_res_o),
    .wbsel_o      (wbsel_o),
    .brtaken_o    (brtaken_o),
    .rd_o         (rd_o),
    .regwren_o    (regwren_o),
    .memory_data_o(memory_data_o),
    .misaligned_o (misaligned_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(string tag);
    chk({tag, ".valid"},   32'(valid_o),      32'(e_valid));
    chk({tag, ".pc"},      pc_o,              e_pc);
    chk({tag, ".alu"},     alu_res_o,         e_alu);
    chk({tag, ".data"},    memory_data_o,     e_data);
    chk({tag, ".wbsel"},   32'(wbsel_o),      32'(e_wbsel));
    chk({tag, ".br"},      32'(brtaken_o),    32'(e_br));
    chk({tag, ".rd"},      32'(rd_o),         32'(e_rd));
    chk({tag, ".regwren"}, 32'(regwren_o),    32'(e_rwe));
    chk({tag, ".mis"},     32'(misaligned_o), 32'(e_mis));
  endtask

  task automatic clear_expect();
    e_valid = 0; e_pc = 0; e_alu = 0; e_data = 0; e_wbsel = 0;
    e_br = 0; e_rd = 0; e_rwe = 0; e_mis = 0;
  endtask

  function automatic int access_bytes(logic [2:0] f3);
    case (f3[1:0])
      2'd0:    return 1;
      2'd1:    return 2;
      2'd2:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit is_misaligned(logic [31:0] off, logic [2:0] f3);
    int n;
    n = access_bytes(f3);
    return (n == 2 || n == 4) && (off % n != 0);
  endfunction

  function automatic logic [31:0] model_load(logic [31:0] off, logic [2:0] f3);
    int o;
    logic [7:0]  b;
    logic [15:0] h;
    o = int'(off);
    b = model_b[o];
    case (f3)
      3'b000: return 32'($signed(b));
      3'b001: begin h = {model_b[o+1], model_b[o]}; return 32'($signed(h)); end
      3'b010: return {model_b[o+3], model_b[o+2], model_b[o+1], model_b[o]};
      3'b100: return 32'(b);
      3'b101: begin h = {model_b[o+1], model_b[o]}; return 32'(h); end
      default: return 32'd0;
    endcase
  endfunction

  // Predict from the current inputs, update the model RAM, clock once, compare.
  task automatic step(string tag);
    logic [31:0] off;
    bit          inr, mis;
    off = alu_res_i - Base;
    inr = off < RamBytes;
    mis = is_misaligned(off, funct3_i);
    if (flush_i) begin
      clear_expect();
    end else if (!stall_i) begin
      e_valid = valid_i;
      e_pc    = pc_i;
      e_alu   = alu_res_i;
      e_data  = (memren_i && inr && !mis) ? model_load(off, funct3_i) : 32'd0;
      e_wbsel = wbsel_i;
      e_br    = brtaken_i;
      e_rd    = rd_i;
      e_rwe   = valid_i && regwren_i;
      e_mis   = valid_i && (memren_i || memwren_i) && inr && mis;
    end
    if (valid_i && memwren_i && !stall_i && !flush_i && inr && !mis && funct3_i <= 3'd2) begin
      for (int k = 0; k < access_bytes(funct3_i); k++)
        model_b[int'(off) + k] = rs2_data_i[8*k +: 8];
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic set_op(bit ren, bit wen, logic [2:0] f3, logic [31:0] addr, logic [31:0] data);
    valid_i = 1; stall_i = 0; flush_i = 0;
    memren_i = ren; memwren_i = wen; funct3_i = f3;
    alu_res_i = addr; rs2_data_i = data;
    pc_i = $urandom; brtaken_i = 1'($urandom); rd_i = 5'($urandom);
    wbsel_i = ren ? WB_MEM : WB_ALU;
    regwren_i = ren;
  endtask

  initial begin
    reset = 1;
    set_op(0, 0, 3'd0, 32'd0, 32'd0);
    valid_i = 0;
    clear_expect();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    #2 reset = 0;

    // Give every RAM word a known value.
    for (int w = 0; w < RamBytes / 4; w++) begin
      set_op(0, 1, 3'b010, Base + 32'(w * 4), $urandom);
      step("init");
    end

    set_op(0, 1, 3'b010, 32'h0100_0010, 32'hDEAD_BEEF); step("sw");
    set_op(1, 0, 3'b010, 32'h0100_0010, 32'd0);         step("lw");
    chk("lw_const", memory_data_o, 32'hDEAD_BEEF);
    chk("lw_wbsel", 32'(wbsel_o), 32'(WB_MEM));

    set_op(0, 1, 3'b010, 32'h0100_0020, 32'h8070_F0FF); step("sw2");
    set_op(1, 0, 3'b000, 32'h0100_0020, 32'd0); step("lb");  chk("lb_c",  memory_data_o, 32'hFFFF_FFFF);
    set_op(1, 0, 3'b100, 32'h0100_0020, 32'd0); step("lbu"); chk("lbu_c", memory_data_o, 32'h0000_00FF);
    set_op(1, 0, 3'b001, 32'h0100_0022, 32'd0); step("lh");  chk("lh_c",  memory_data_o, 32'hFFFF_8070);
    set_op(1, 0, 3'b101, 32'h0100_0022, 32'd0); step("lhu"); chk("lhu_c", memory_data_o, 32'h0000_8070);

    set_op(0, 1, 3'b010, 32'h0100_0020, 32'h1122_3344); step("sw3");
    set_op(0, 1, 3'b000, 32'h0100_0021, 32'h0000_00AB); step("sb");
    set_op(1, 0, 3'b010, 32'h0100_0020, 32'd0); step("lw_sb"); chk("sb_c", memory_data_o, 32'h1122_AB44);
    set_op(0, 1, 3'b001, 32'h0100_0022, 32'h0000_5566); step("sh");
    set_op(1, 0, 3'b010, 32'h0100_0020, 32'd0); step("lw_sh"); chk("sh_c", memory_data_o, 32'h5566_AB44);

    set_op(0, 1, 3'b010, 32'h0100_0022, 32'hFFFF_FFFF); step("sw_mis"); chk("sw_mis_c", 32'(misaligned_o), 32'd1);
    set_op(1, 0, 3'b010, 32'h0100_0020, 32'd0); step("lw_mis"); chk("mis_keep_c", memory_data_o, 32'h5566_AB44);
    set_op(1, 0, 3'b001, 32'h0100_0023, 32'd0); step("lh_mis");
    chk("lh_mis_d", memory_data_o, 32'd0);
    chk("lh_mis_f", 32'(misaligned_o), 32'd1);

    // Stalled store, then committed on the first unstalled edge.
    set_op(0, 1, 3'b010, 32'h0100_0030, 32'hCAFE_F00D);
    stall_i = 1; step("stall1"); step("stall2");
    chk("stall_hold", memory_data_o, 32'h5566_AB44 & 32'h0);
    stall_i = 0; step("unstall");
    set_op(1, 0, 3'b010, 32'h0100_0030, 32'd0); step("lw_stall"); chk("stall_c", memory_data_o, 32'hCAFE_F00D);
    // Stalled store abandoned: RAM must not change.
    set_op(0, 1, 3'b010, 32'h0100_0030, 32'h1234_5678);
    stall_i = 1; step("stall3"); step("stall4");
    set_op(1, 0, 3'b010, 32'h0100_0030, 32'd0); step("lw_abandon"); chk("abandon_c", memory_data_o, 32'hCAFE_F00D);

    set_op(0, 1, 3'b010, 32'h0100_0030, 32'h0BAD_F00D); flush_i = 1; step("flush");
    chk("flush_v", 32'(valid_o), 32'd0);
    set_op(1, 0, 3'b010, 32'h0100_0030, 32'd0); step("lw_flush"); chk("flush_c", memory_data_o, 32'hCAFE_F00D);

    set_op(1, 0, 3'b010, Base + RamBytes, 32'd0);  step("oor_hi");
    set_op(1, 0, 3'b010, 32'h00FF_FFFC, 32'd0);    step("oor_lo");
    set_op(0, 1, 3'b010, Base + RamBytes, 32'd7);  step("oor_sw");

    // Asynchronous reset mid-cycle, with a store pending on the reset edge.
    set_op(1, 0, 3'b010, 32'h0100_0040, 32'd0); step("pre_rst");
    set_op(0, 1, 3'b010, 32'h0100_0040, 32'hFFFF_0000);
    #2 reset = 1;
    #1 clear_expect();
    check_outputs("rst_async");
    @(posedge clk); #1;
    check_outputs("rst_edge");
    #2 reset = 0;
    set_op(1, 0, 3'b010, 32'h0100_0040, 32'd0); step("lw_after_rst");

    for (int i = 0; i < 600; i++) begin
      valid_i    = ($urandom % 8) != 0;
      stall_i    = ($urandom % 7) == 0;
      flush_i    = ($urandom % 10) == 0;
      memren_i   = 1'($urandom);
      memwren_i  = ($urandom % 3) == 0;
      funct3_i   = 3'($urandom);
      alu_res_i  = (($urandom % 16) == 0) ? $urandom : Base + ($urandom % RamBytes);
      rs2_data_i = $urandom;
      pc_i       = $urandom;
      wbsel_i    = 2'($urandom % 3);
      brtaken_i  = 1'($urandom);
      rd_i       = 5'($urandom);
      regwren_i  = 1'($urandom);
      step("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
